// File: rtl/fir_sweep_pkg.sv
// Shared types for the FIR frequency sweeper: FSM state encoding and NCO tone table.
// Ports: none (package).
// Tone k sits at k*FS/32 Hz, so index 0 is DC and index 15 stays below Nyquist.
package fir_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_REPORT
  } state_t;

  // 16 phase increments, one per frequency select, for a 32-bit accumulator.
  typedef logic [15:0][31:0] phase_tbl_t;

  // inc = f * 2^32 / fclk with f = k * fs / 32, i.e. k * fs * 2^27 / fclk.
  function automatic phase_tbl_t phase_inc_table(input longint unsigned fclk,
                                                 input longint unsigned fs);
    phase_tbl_t t;
    for (int k = 0; k < 16; k++) begin
      t[k] = 32'(((64'(k) * fs) << 27) / fclk);
    end
    return t;
  endfunction

endpackage

// File: rtl/fir_path.sv
// Boxcar FIR path: y is the saturated sum of the last N samples taken on clk_en.
// Ports: clk, rst (sync, active-high), clk_en (sample strobe), x (signed in), y (signed out).
// y follows the tap registers combinationally, so it is valid the cycle after clk_en.
module fir_path #(
  parameter int N = 8,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] y
);

  localparam int SW = W + $clog2(N + 1);
  localparam logic signed [SW-1:0] YMAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] YMIN = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [W-1:0]  taps [N];
  logic signed [SW-1:0] sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) taps[i] <= '0;
    end else if (clk_en) begin
      taps[0] <= x;
      for (int i = 1; i < N; i++) taps[i] <= taps[i-1];
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + SW'(taps[i]);
  end

  always_comb begin
    if (sum > YMAX)      y = YMAX[W-1:0];
    else if (sum < YMIN) y = YMIN[W-1:0];
    else                 y = sum[W-1:0];
  end

endmodule

// File: rtl/fir_sweep_peak.sv
// peak_meter: running max of |y|, with the most negative code clamped to the largest positive one.
// Ports: clk, rst (sync, active-high), clear (zero the peak), en (fold in y this cycle), y, peak.
// clear wins over en; peak is unsigned and never exceeds 2^(W-1)-1.
module peak_meter #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  input  logic signed [W-1:0] y,
  output logic        [W-1:0] peak
);

  localparam logic signed [W-1:0] YMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic        [W-1:0] MMAX = {1'b0, {(W-1){1'b1}}};

  logic [W-1:0] mag;

  // Negating YMIN overflows back to YMIN, so it is clamped explicitly.
  always_comb begin
    if (y == YMIN)   mag = MMAX;
    else if (y[W-1]) mag = $unsigned(-y);
    else             mag = $unsigned(y);
  end

  always_ff @(posedge clk) begin
    if (rst || clear)           peak <= '0;
    else if (en && (mag > peak)) peak <= mag;
  end

endmodule

// File: rtl/fir_sweep_top.sv
// Frequency sweeper: drives a square-wave tone per select into fir_path and reports the output peak.
// Ports: clk, rst; start/abort/cont/first_sel/last_sel control; res_* result with valid/ready;
//        busy status; xpin/ypin scope taps (MSB of x and y).
module fir_sweep_top #(
  parameter int N      = 8,
  parameter int FCLK   = 50_000_000,
  parameter int FS     = 48000,
  parameter int W      = 16,
  parameter int AMP    = 4096,
  parameter int SETTLE = 64,
  parameter int MEAS   = 1024,
  parameter int THRESH = 8192
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         cont,
  input  logic [3:0]   first_sel,
  input  logic [3:0]   last_sel,
  output logic         busy,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [3:0]   res_sel,
  output logic [W-1:0] res_peak,
  output logic         res_det,
  output logic         xpin,
  output logic         ypin
);
  import fir_sweep_pkg::*;

  localparam int P  = FCLK / FS;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam phase_tbl_t PHASE_INC = phase_inc_table(FCLK, FS);
  localparam logic signed [W-1:0] AMP_V = W'(AMP);

  state_t state_q, state_d;
  logic [3:0]  sel_q, sel_d, first_q, last_q;
  logic        cont_q;
  logic [31:0] smp_cnt;
  logic        load_cfg, cnt_clr, cnt_inc, peak_clr, rep_load;

  // Sample strobe: one clk_en per P cycles; clk_en_d marks the cycle y is fresh.
  logic [CW-1:0] en_cnt;
  logic          clk_en, clk_en_d;

  assign clk_en = (en_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      en_cnt   <= '0;
      clk_en_d <= 1'b0;
    end else begin
      en_cnt   <= (en_cnt == CW'(P - 1)) ? '0 : en_cnt + CW'(1);
      clk_en_d <= clk_en;
    end
  end

  // NCO: square wave from the accumulator MSB, restarted at phase 0 on start.
  logic [31:0]         acc;
  logic signed [W-1:0] x, y;
  logic [W-1:0]        peak;

  always_ff @(posedge clk) begin
    if (rst || load_cfg) acc <= '0;
    else                 acc <= acc + PHASE_INC[sel_q];
  end

  assign x = acc[31] ? AMP_V : -AMP_V;

  fir_path #(.N(N), .W(W)) u_fir (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .x      (x),
    .y      (y)
  );

  peak_meter #(.W(W)) u_peak (
    .clk   (clk),
    .rst   (rst),
    .clear (peak_clr),
    .en    (cnt_inc && (state_q == S_MEASURE)),
    .y     (y),
    .peak  (peak)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // MEASURE leaves one cycle after the last update so res_peak sees it.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    load_cfg = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    peak_clr = 1'b0;
    rep_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SETTLE;
          sel_d    = first_sel;
          load_cfg = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (clk_en) begin
          if (smp_cnt == 32'(SETTLE - 1)) begin
            state_d  = S_MEASURE;
            cnt_clr  = 1'b1;
            peak_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_MEASURE: begin
        if (smp_cnt == 32'(MEAS)) begin
          state_d  = S_REPORT;
          rep_load = 1'b1;
        end else if (clk_en_d) begin
          cnt_inc = 1'b1;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          cnt_clr = 1'b1;
          state_d = S_SETTLE;
          if (sel_q != last_q) sel_d = sel_q + 4'd1;
          else if (cont_q)     sel_d = first_q;
          else                 state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      sel_d    = sel_q;
      load_cfg = 1'b0;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      peak_clr = 1'b0;
      rep_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      first_q  <= '0;
      last_q   <= '0;
      cont_q   <= 1'b0;
      smp_cnt  <= '0;
      res_sel  <= '0;
      res_peak <= '0;
      res_det  <= 1'b0;
    end else begin
      sel_q <= sel_d;
      if (load_cfg) begin
        first_q <= first_sel;
        last_q  <= last_sel;
        cont_q  <= cont;
      end
      if (cnt_clr)      smp_cnt <= '0;
      else if (cnt_inc) smp_cnt <= smp_cnt + 32'd1;
      if (rep_load) begin
        res_sel  <= sel_q;
        res_peak <= peak;
        res_det  <= (32'(peak) >= 32'(THRESH));
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_REPORT);
  assign xpin      = x[W-1];
  assign ypin      = y[W-1];

endmodule

// File: tb/tb_fir_sweep_top.sv
// Directed bench for fir_sweep_top: sample strobe period, sweep order, hold, peak/threshold, abort, reset.
// Ports: none; a second instance (1 tap, AMP 8191) shares the stimulus for the below-threshold peak.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_fir_sweep_top;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0, cont = 1'b0, res_ready = 1'b0;
  logic [3:0] first_sel = '0, last_sel = '0;

  logic busy, res_valid, res_det, xpin, ypin;
  logic [3:0]  res_sel;
  logic [15:0] res_peak;
  logic lo_busy, lo_res_valid, lo_res_det, lo_xpin, lo_ypin;
  logic [3:0]  lo_res_sel;
  logic [15:0] lo_res_peak;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fir_sweep_top #(.N(8), .FCLK(4800), .FS(48), .W(16), .AMP(4096),
                  .SETTLE(4), .MEAS(8), .THRESH(8192)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont),
    .first_sel(first_sel), .last_sel(last_sel), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_sel(res_sel), .res_peak(res_peak), .res_det(res_det),
    .xpin(xpin), .ypin(ypin)
  );

  fir_sweep_top #(.N(1), .FCLK(4800), .FS(48), .W(16), .AMP(8191),
                  .SETTLE(4), .MEAS(8), .THRESH(8192)) u_lo (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont),
    .first_sel(first_sel), .last_sel(last_sel), .busy(lo_busy), .res_valid(lo_res_valid),
    .res_ready(res_ready), .res_sel(lo_res_sel), .res_peak(lo_res_peak), .res_det(lo_res_det),
    .xpin(lo_xpin), .ypin(lo_ypin)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Advances at least one cycle, then up to 3000 until res_valid is seen.
  task automatic wait_valid(input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!res_valid && k < 3000);
    if (!res_valid) check({tag, "_timeout"}, 32'(res_valid), 1);
  endtask

  task automatic pulse_start(input logic [3:0] f, input logic [3:0] l, input logic c);
    first_sel = f;
    last_sel  = l;
    cont      = c;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    logic [3:0]  h_sel;
    logic [15:0] h_peak;
    logic        h_det;
    int          changes;
    int          k;

    // Reset state
    repeat (3) tick();
    check("rst_busy",      32'(busy),      0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_sel",   32'(res_sel),   0);
    check("rst_res_peak",  32'(res_peak),  0);
    check("rst_res_det",   32'(res_det),   0);
    rst = 1'b0;

    // Sample strobe period: P = 4800/48 = 100 cycles
    k = 0;
    while (!u_dut.clk_en && k < 200) begin tick(); k++; end
    for (int p = 0; p < 10; p++) begin
      k = 0;
      do begin tick(); k++; end while (!u_dut.clk_en && k < 200);
      check("clk_en_period", 32'(k), 100);
    end

    // Sweep 3..5, always ready; a start mid-sweep must be ignored
    res_ready = 1'b1;
    pulse_start(4'd3, 4'd5, 1'b0);
    wait_valid("sw_a");
    check("sweep_sel_3", 32'(res_sel), 3);
    tick();
    pulse_start(4'd9, 4'd9, 1'b0);
    wait_valid("sw_b");
    check("sweep_sel_4", 32'(res_sel), 4);
    wait_valid("sw_c");
    check("sweep_sel_5", 32'(res_sel), 5);
    tick();
    check("sweep_done_busy",  32'(busy),      0);
    check("sweep_done_valid", 32'(res_valid), 0);

    // Backpressure: hold for 50 cycles, result must stay frozen
    res_ready = 1'b0;
    pulse_start(4'd7, 4'd8, 1'b0);
    wait_valid("hold_a");
    check("hold_sel_7", 32'(res_sel), 7);
    h_sel = res_sel; h_peak = res_peak; h_det = res_det;
    changes = 0;
    repeat (50) begin
      tick();
      if (res_valid !== 1'b1 || res_sel !== h_sel || res_peak !== h_peak || res_det !== h_det)
        changes++;
    end
    check("hold_stable", 32'(changes), 0);
    res_ready = 1'b1;
    tick();
    check("hold_accept_valid", 32'(res_valid), 0);
    check("hold_accept_busy",  32'(busy),      1);
    wait_valid("hold_b");
    check("hold_sel_8", 32'(res_sel), 8);
    tick();
    check("hold_done_busy", 32'(busy), 0);

    // DC tone (sel 0): 8 taps of -4096 give y = -32768 -> peak clamps to 32767.
    // 1-tap instance sees y = -8191 -> peak 8191, just under threshold.
    res_ready = 1'b0;
    pulse_start(4'd0, 4'd0, 1'b0);
    wait_valid("peak");
    check("peak_sat",      32'(res_peak),     32767);
    check("peak_sat_det",  32'(res_det),      1);
    check("peak_xpin",     32'(xpin),         1);
    check("peak_ypin",     32'(ypin),         1);
    check("lo_valid",      32'(lo_res_valid), 1);
    check("lo_sel",        32'(lo_res_sel),   0);
    check("lo_peak",       32'(lo_res_peak),  8191);
    check("lo_det",        32'(lo_res_det),   0);
    check("lo_xpin",       32'(lo_xpin),      1);
    check("lo_ypin",       32'(lo_ypin),      1);
    res_ready = 1'b1;
    tick();
    check("peak_done_busy", 32'(busy),    0);
    check("lo_done_busy",   32'(lo_busy), 0);

    // Continuous wrap sweep 15 -> 0, then abort in REPORT (beats the handshake)
    pulse_start(4'd15, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_valid("wrap");
      check("wrap_sel", 32'(res_sel), (i % 2 == 0) ? 32'd15 : 32'd0);
    end
    tick();
    res_ready = 1'b0;
    wait_valid("wrap_5");
    check("wrap_sel_5", 32'(res_sel), 15);
    abort     = 1'b1;
    res_ready = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",  32'(busy),      0);
    check("abort_valid", 32'(res_valid), 0);
    repeat (300) tick();
    check("abort_stays_idle", 32'(busy), 0);

    // start together with abort is dropped
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 0);

    // Reset while measuring
    pulse_start(4'd2, 4'd2, 1'b0);
    repeat (600) tick();
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy",      32'(busy),      0);
    check("mrst_res_valid", 32'(res_valid), 0);
    check("mrst_res_sel",   32'(res_sel),   0);
    check("mrst_res_peak",  32'(res_peak),  0);
    check("mrst_res_det",   32'(res_det),   0);
    check("mrst_ypin",      32'(ypin),      0);
    changes = 0;
    repeat (2000) begin
      tick();
      if (res_valid || busy) changes++;
    end
    check("mrst_quiet", 32'(changes), 0);
    pulse_start(4'd6, 4'd6, 1'b0);
    wait_valid("post_rst");
    check("post_rst_sel", 32'(res_sel), 6);
    tick();
    check("post_rst_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
